// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder: digit width, BCD limits
// and the controller state encoding.
package bcd_pkg;

    localparam int         DIGIT_W  = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'b0110;

    typedef enum logic {
        IDLE,
        ADD
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal correction and invalid-digit detection.
// Purely combinational; the serial top time-multiplexes one instance.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co,
    output logic               inv
);

    logic [DIGIT_W:0]   raw_sum;
    logic [DIGIT_W-1:0] corr_sum;

    assign raw_sum  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, ci};
    // Only the low nibble of the corrected sum is kept, so a 4-bit add suffices.
    assign corr_sum = raw_sum[DIGIT_W-1:0] + BCD_CORR;
    assign co       = (raw_sum > {1'b0, BCD_MAX});
    assign s        = co ? corr_sum : raw_sum[DIGIT_W-1:0];
    assign inv      = (a > BCD_MAX) || (b > BCD_MAX);

endmodule

// File: rtl/bcd_serial_adder3.sv
// Digit-serial BCD adder: one digit per clock, LSD first, with a
// start/busy/done handshake and a sticky invalid-digit flag.
module bcd_serial_adder3
    import bcd_pkg::*;
#(
    parameter int NDIG = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIGIT_W*NDIG-1:0] A,
    input  logic [DIGIT_W*NDIG-1:0] B,
    input  logic                    Cin,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*NDIG-1:0] Sum,
    output logic                    Cout,
    output logic                    err
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

    state_t                    state_reg, state_next;
    logic [IDX_W-1:0]          idx_reg, idx_next;
    logic [DIGIT_W*NDIG-1:0]   a_reg, a_next;
    logic [DIGIT_W*NDIG-1:0]   b_reg, b_next;
    logic [DIGIT_W*NDIG-1:0]   sum_reg, sum_next;
    logic                      c_reg, c_next;
    logic                      cout_reg, cout_next;
    logic                      err_reg, err_next;
    logic                      done_reg, done_next;

    logic [DIGIT_W-1:0] a_digs [NDIG];
    logic [DIGIT_W-1:0] b_digs [NDIG];
    logic [DIGIT_W-1:0] a_dig, b_dig, d_sum;
    logic               d_co, d_inv;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_dig
            assign a_digs[gi] = a_reg[gi*DIGIT_W +: DIGIT_W];
            assign b_digs[gi] = b_reg[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    // Operand digit selected by the current index feeds the shared digit adder.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                a_dig = a_digs[i];
                b_dig = b_digs[i];
            end
        end
    end

    bcd_digit_add u_digit (
        .a   (a_dig),
        .b   (b_dig),
        .ci  (c_reg),
        .s   (d_sum),
        .co  (d_co),
        .inv (d_inv)
    );

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        c_next     = c_reg;
        cout_next  = cout_reg;
        err_next   = err_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = A;
                    b_next     = B;
                    c_next     = Cin;
                    sum_next   = '0;
                    err_next   = 1'b0;
                    idx_next   = '0;
                    state_next = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (idx_reg == IDX_W'(i)) begin
                        sum_next[i*DIGIT_W +: DIGIT_W] = d_sum;
                    end
                end
                c_next   = d_co;
                err_next = err_reg | d_inv;
                if (idx_reg == LAST_IDX) begin
                    cout_next  = d_co;
                    done_next  = 1'b1;
                    idx_next   = '0;
                    state_next = IDLE;
                end else begin
                    idx_next = idx_reg + IDX_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            c_reg     <= 1'b0;
            cout_reg  <= 1'b0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            c_reg     <= c_next;
            cout_reg  <= cout_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
        end
    end

    assign busy = (state_reg == ADD);
    assign done = done_reg;
    assign Sum  = sum_reg;
    assign Cout = cout_reg;
    assign err  = err_reg;

endmodule
